// File: rtl/led_status_if.sv
// Bundles the per-channel configuration, activity events and status outputs of
// the LED/uptime controller so the top level can pass them as one port.
interface led_status_if #(
    parameter int unsigned CHANNELS = 2
);
    logic [2*CHANNELS-1:0]  mode;
    logic [16*CHANNELS-1:0] blink_half_ms;
    logic [CHANNELS-1:0]    act_pulse;
    logic [CHANNELS-1:0]    led_out;
    logic                   ms_tick;
    logic                   sec_tick;
    logic [31:0]            uptime_seconds;

    modport master (
        output mode, blink_half_ms, act_pulse,
        input  led_out, ms_tick, sec_tick, uptime_seconds
    );

    modport slave (
        input  mode, blink_half_ms, act_pulse,
        output led_out, ms_tick, sec_tick, uptime_seconds
    );
endinterface

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED controller (off/on/blink/activity) sharing one
// millisecond prescaler that also drives a seconds tick and uptime counter.
//
// Activity FSM states:
//   state    | meaning
//   ACT_IDLE | LED dark, waiting for an act_pulse
//   ACT_ON   | LED lit for STRETCH_MS ticks, further pulses set pending
//   ACT_GAP  | LED forced dark for GAP_MS ticks, then replay if pending
module led_status_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 125000000,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned STRETCH_MS  = 50,
    parameter int unsigned GAP_MS      = 30,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    led_status_if.slave bus
);
    localparam int unsigned   DIV     = CLK_FREQ_HZ / 1000;
    localparam int unsigned   DW      = $clog2(DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [15:0]   STRETCH = 16'(STRETCH_MS);
    localparam logic [15:0]   GAP     = 16'(GAP_MS);

    typedef enum logic [1:0] {ACT_IDLE, ACT_ON, ACT_GAP} act_state_e;

    logic [DW-1:0] div_q;
    logic [9:0]    ms_q;
    logic [31:0]   uptime_q;
    logic          ms_tick;
    logic          sec_tick;

    // Ticks decode registered counters only, so they are single-cycle and clean.
    assign ms_tick  = (div_q == DIV_MAX);
    assign sec_tick = ms_tick && (ms_q == 10'd999);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            ms_q     <= '0;
            uptime_q <= '0;
        end else begin
            if (ms_tick) begin
                div_q <= '0;
                ms_q  <= (ms_q == 10'd999) ? 10'd0 : ms_q + 10'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (sec_tick) begin
                uptime_q <= uptime_q + 32'd1;
            end
        end
    end

    assign bus.ms_tick        = ms_tick;
    assign bus.sec_tick       = sec_tick;
    assign bus.uptime_seconds = uptime_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]  mode_in, mode_q;
        logic [15:0] half_in, half_eff;
        logic [15:0] blink_cnt_q, blink_cnt_d;
        logic        blink_ph_q, blink_ph_d;
        act_state_e  act_q, act_d;
        logic [15:0] rem_q, rem_d;
        logic        pend_q, pend_d;
        logic        act_in, changed, lit, led_q;

        assign mode_in  = bus.mode[2*i +: 2];
        assign half_in  = bus.blink_half_ms[16*i +: 16];
        assign half_eff = (half_in == 16'd0) ? 16'd1 : half_in;
        assign act_in   = bus.act_pulse[i];
        assign changed  = (mode_in != mode_q);

        // >= rather than == so a live shrink of the half-period cannot overrun.
        always_comb begin
            blink_cnt_d = blink_cnt_q;
            blink_ph_d  = blink_ph_q;
            if (changed || mode_q != 2'b10) begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b1;
            end else if (ms_tick) begin
                if (blink_cnt_q >= half_eff - 16'd1) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 16'd1;
                end
            end
        end

        always_comb begin
            act_d  = act_q;
            rem_d  = rem_q;
            pend_d = pend_q;
            if (changed || mode_q != 2'b11) begin
                act_d  = ACT_IDLE;
                rem_d  = '0;
                pend_d = 1'b0;
            end else begin
                case (act_q)
                    ACT_IDLE: begin
                        if (act_in) begin
                            act_d = ACT_ON;
                            rem_d = STRETCH;
                        end
                    end
                    ACT_ON: begin
                        if (act_in) pend_d = 1'b1;
                        if (ms_tick) begin
                            if (rem_q == 16'd1) begin
                                act_d = ACT_GAP;
                                rem_d = GAP;
                            end else begin
                                rem_d = rem_q - 16'd1;
                            end
                        end
                    end
                    ACT_GAP: begin
                        if (ms_tick && rem_q == 16'd1) begin
                            pend_d = 1'b0;
                            if (pend_q || act_in) begin
                                act_d = ACT_ON;
                                rem_d = STRETCH;
                            end else begin
                                act_d = ACT_IDLE;
                                rem_d = '0;
                            end
                        end else begin
                            if (act_in) pend_d = 1'b1;
                            if (ms_tick) rem_d = rem_q - 16'd1;
                        end
                    end
                    default: begin
                        act_d  = ACT_IDLE;
                        rem_d  = '0;
                        pend_d = 1'b0;
                    end
                endcase
            end
        end

        // Driven from the registered mode, giving the two-cycle mode-to-pin latency.
        always_comb begin
            case (mode_q)
                2'b00:   lit = 1'b0;
                2'b01:   lit = 1'b1;
                2'b10:   lit = blink_ph_q;
                default: lit = (act_q == ACT_ON);
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q      <= 2'b00;
                blink_cnt_q <= '0;
                blink_ph_q  <= 1'b1;
                act_q       <= ACT_IDLE;
                rem_q       <= '0;
                pend_q      <= 1'b0;
                led_q       <= ACTIVE_LOW;
            end else begin
                mode_q      <= mode_in;
                blink_cnt_q <= blink_cnt_d;
                blink_ph_q  <= blink_ph_d;
                act_q       <= act_d;
                rem_q       <= rem_d;
                pend_q      <= pend_d;
                led_q       <= lit ^ ACTIVE_LOW;
            end
        end

        assign bus.led_out[i] = led_q;
    end
endmodule
